// File: rtl/sorter_arb_pkg.sv
// Shared types and helpers for the sorter arbiter slice: FSM state
// encoding, grant-index width and the round-robin pointer advance.
package sorter_arb_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        XFER      = 3'd1,
        DROP      = 3'd2,
        WAIT_BUSY = 3'd3,
        WAIT_DONE = 3'd4
    } state_t;

    // Width of a requester index; never narrower than one bit.
    function automatic int grant_w(input int num_req);
        return (num_req > 1) ? $clog2(num_req) : 1;
    endfunction

    // Requester index that follows idx, wrapping at num_req.
    function automatic int rr_next(input int idx, input int num_req);
        return (idx + 1 >= num_req) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: the first set request at or above
// ptr wins, otherwise the first set request below ptr. Outputs a one-hot
// grant and the matching index.
module rr_arbiter
    import sorter_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int GRANT_W = grant_w(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [GRANT_W-1:0] ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic [GRANT_W-1:0] gnt_idx
);

    logic found;

    // Two ordered scans: upper half from ptr first, then the wrap-around part.
    always_comb begin
        // NOTE: every signal written here gets a default first so no latch is inferred.
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && req[i] && (GRANT_W'(i) >= ptr)) begin
                gnt[i]  = 1'b1;
                gnt_idx = GRANT_W'(i);
                found   = 1'b1;
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && req[i] && (GRANT_W'(i) < ptr)) begin
                gnt[i]  = 1'b1;
                gnt_idx = GRANT_W'(i);
                found   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sorter_arbiter.sv
// Shares one sorter sink port between NUM_REQ packet sources. Grants
// round-robin per packet, forwards the packet with one cycle of latency,
// truncates at MAX_LENGTH words (remaining words are drained silently) and
// then waits for the sorter's ready to fall and rise again before the next
// grant. If ready never falls within BUSY_TIMEOUT cycles the job is
// considered not taken and the arbiter returns to IDLE.
// Optional build macro SORTER_ARB_STATS_EN adds pkt_cnt / trunc_cnt outputs.
module sorter_arbiter
    import sorter_arb_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int MAX_LENGTH   = 16,
    parameter int NUM_REQ      = 4,
    parameter int BUSY_TIMEOUT = 64
) (
    input  logic                            snk_clock,
    input  logic                            snk_reset_n,
    input  logic [NUM_REQ-1:0]              req_valid,
    input  logic [NUM_REQ-1:0]              req_sop,
    input  logic [NUM_REQ-1:0]              req_eop,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_data,
    output logic [NUM_REQ-1:0]              req_ready,
    input  logic                            srt_ready,
    output logic                            srt_valid,
    output logic                            srt_sop,
    output logic                            srt_eop,
    output logic [DATA_WIDTH-1:0]           srt_data,
    output logic [grant_w(NUM_REQ)-1:0]     grant_id,
    output logic                            busy
`ifdef SORTER_ARB_STATS_EN
    ,
    output logic [15:0]                     pkt_cnt,
    output logic [15:0]                     trunc_cnt
`endif
);

    localparam int GRANT_W = grant_w(NUM_REQ);
    localparam int CNT_W   = $clog2(MAX_LENGTH) + 1;
    localparam int TMR_W   = $clog2(BUSY_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(MAX_LENGTH - 1);
    localparam logic [TMR_W-1:0] LAST_TICK = TMR_W'(BUSY_TIMEOUT - 1);

    state_t                 state;
    state_t                 next_state;
    logic                   rdy_meta;
    logic                   rdy_s;
    logic [GRANT_W-1:0]     ptr;
    logic [CNT_W-1:0]       word_cnt;
    logic [TMR_W-1:0]       busy_tmr;

    logic [NUM_REQ-1:0]     arb_gnt;
    logic [GRANT_W-1:0]     arb_idx;
    logic                   arb_any;

    logic [NUM_REQ-1:0]     sel_onehot;
    logic                   cur_valid;
    logic                   cur_eop;
    logic [DATA_WIDTH-1:0]  cur_data;

    logic                   do_grant;
    logic                   fwd_word;
    logic                   pkt_done;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .GRANT_W (GRANT_W)
    ) u_rr_arbiter (
        .req     (req_valid & req_sop),
        .ptr     (ptr),
        .gnt     (arb_gnt),
        .gnt_idx (arb_idx)
    );

    assign arb_any = |arb_gnt;
    assign busy    = (state != IDLE);

    // Bring the sorter's ready into this clock domain before any use.
    always_ff @(posedge snk_clock or negedge snk_reset_n) begin
        if (!snk_reset_n) begin
            rdy_meta <= 1'b0;
            rdy_s    <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            rdy_meta <= srt_ready;
            rdy_s    <= rdy_meta;
        end
    end

    // Select the granted requester's word and its one-hot ready position.
    always_comb begin
        sel_onehot = '0;
        cur_valid  = 1'b0;
        cur_eop    = 1'b0;
        cur_data   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_id == GRANT_W'(i)) begin
                sel_onehot[i] = 1'b1;
                cur_valid     = req_valid[i];
                cur_eop       = req_eop[i];
                cur_data      = req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // FSM state register.
    always_ff @(posedge snk_clock or negedge snk_reset_n) begin
        if (!snk_reset_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // FSM next state plus the ready vector and datapath strobes.
    always_comb begin
        next_state = state;
        req_ready  = '0;
        do_grant   = 1'b0;
        fwd_word   = 1'b0;
        pkt_done   = 1'b0;
        case (state)
            IDLE: begin
                if (rdy_s && arb_any) begin
                    do_grant   = 1'b1;
                    next_state = XFER;
                end
            end
            XFER: begin
                req_ready = sel_onehot;
                fwd_word  = cur_valid;
                if (cur_valid && cur_eop) begin
                    pkt_done   = 1'b1;
                    next_state = WAIT_BUSY;
                end else if (cur_valid && (word_cnt == LAST_WORD)) begin
                    next_state = DROP;
                end
            end
            DROP: begin
                req_ready = sel_onehot;
                if (cur_valid && cur_eop) begin
                    pkt_done   = 1'b1;
                    next_state = WAIT_BUSY;
                end
            end
            WAIT_BUSY: begin
                if (!rdy_s) begin
                    next_state = WAIT_DONE;
                end else if (busy_tmr == LAST_TICK) begin
                    next_state = IDLE;
                end
            end
            WAIT_DONE: begin
                if (rdy_s) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Output registers, grant/pointer bookkeeping, word count and busy timer.
    always_ff @(posedge snk_clock or negedge snk_reset_n) begin
        if (!snk_reset_n) begin
            srt_valid <= 1'b0;
            srt_sop   <= 1'b0;
            srt_eop   <= 1'b0;
            srt_data  <= '0;
            grant_id  <= '0;
            ptr       <= '0;
            word_cnt  <= '0;
            busy_tmr  <= '0;
        end else begin
            srt_valid <= fwd_word;
            srt_sop   <= fwd_word && (word_cnt == '0);
            srt_eop   <= fwd_word && (cur_eop || (word_cnt == LAST_WORD));
            if (fwd_word) begin
                srt_data <= cur_data;
            end

            if (do_grant) begin
                grant_id <= arb_idx;
                word_cnt <= '0;
            end else if (fwd_word) begin
                word_cnt <= word_cnt + 1'b1;
            end

            if (pkt_done) begin
                ptr <= GRANT_W'(rr_next(int'(grant_id), NUM_REQ));
            end

            // Timer only runs while waiting for ready to fall; clears otherwise.
            if (state == WAIT_BUSY) begin
                busy_tmr <= busy_tmr + 1'b1;
            end else begin
                busy_tmr <= '0;
            end
        end
    end

`ifdef SORTER_ARB_STATS_EN
    // Packet statistics, bumped on entry to WAIT_BUSY; wrap at 2^16.
    always_ff @(posedge snk_clock or negedge snk_reset_n) begin
        if (!snk_reset_n) begin
            pkt_cnt   <= '0;
            trunc_cnt <= '0;
        end else if (pkt_done) begin
            if (state == XFER) begin
                pkt_cnt <= pkt_cnt + 1'b1;
            end else begin
                trunc_cnt <= trunc_cnt + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_sorter_arbiter.sv
// Directed self-checking bench for sorter_arbiter (MAX_LENGTH=4,
// BUSY_TIMEOUT=16). Inputs are driven 1 time unit after the rising edge
// and outputs are checked at the same point.
module tb_sorter_arbiter;

    localparam int DW  = 8;
    localparam int NR  = 4;
    localparam int ML  = 4;
    localparam int BTO = 16;

    logic            snk_clock = 1'b0;
    logic            snk_reset_n;
    logic [NR-1:0]   req_valid;
    logic [NR-1:0]   req_sop;
    logic [NR-1:0]   req_eop;
    logic [NR*DW-1:0] req_data;
    logic [NR-1:0]   req_ready;
    logic            srt_ready;
    logic            srt_valid;
    logic            srt_sop;
    logic            srt_eop;
    logic [DW-1:0]   srt_data;
    logic [1:0]      grant_id;
    logic            busy;
`ifdef SORTER_ARB_STATS_EN
    logic [15:0]     pkt_cnt;
    logic [15:0]     trunc_cnt;
`endif

    int pass_cnt  = 0;
    int check_cnt = 0;

    sorter_arbiter #(
        .DATA_WIDTH   (DW),
        .MAX_LENGTH   (ML),
        .NUM_REQ      (NR),
        .BUSY_TIMEOUT (BTO)
    ) dut (
        .snk_clock   (snk_clock),
        .snk_reset_n (snk_reset_n),
        .req_valid   (req_valid),
        .req_sop     (req_sop),
        .req_eop     (req_eop),
        .req_data    (req_data),
        .req_ready   (req_ready),
        .srt_ready   (srt_ready),
        .srt_valid   (srt_valid),
        .srt_sop     (srt_sop),
        .srt_eop     (srt_eop),
        .srt_data    (srt_data),
        .grant_id    (grant_id),
        .busy        (busy)
`ifdef SORTER_ARB_STATS_EN
        ,
        .pkt_cnt     (pkt_cnt),
        .trunc_cnt   (trunc_cnt)
`endif
    );

    always #5 snk_clock = ~snk_clock;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        check_cnt++;
        assert (observed === expected) pass_cnt++;
        else $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    endtask

    task automatic tick();
        @(posedge snk_clock);
        #1;
    endtask

    task automatic set_word(input int r, input logic sop, input logic eop, input logic [DW-1:0] d);
        req_valid[r] = 1'b1;
        req_sop[r]   = sop;
        req_eop[r]   = eop;
        req_data[r*DW +: DW] = d;
    endtask

    task automatic clr_req(input int r);
        req_valid[r] = 1'b0;
        req_sop[r]   = 1'b0;
        req_eop[r]   = 1'b0;
    endtask

    // Sorter takes the job: ready falls, then rises again.
    task automatic handshake();
        srt_ready = 1'b0;
        repeat (4) tick();
        srt_ready = 1'b1;
        repeat (4) tick();
    endtask

    task automatic pulse_reset();
        snk_reset_n = 1'b0;
        tick();
        snk_reset_n = 1'b1;
        repeat (3) tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        snk_reset_n = 1'b0;
        srt_ready   = 1'b1;
        req_valid   = '0;
        req_sop     = '0;
        req_eop     = '0;
        req_data    = '0;

        // Reset state
        #12;
        check("rst_srt_valid", srt_valid, 0);
        check("rst_srt_sop",   srt_sop,   0);
        check("rst_srt_eop",   srt_eop,   0);
        check("rst_srt_data",  srt_data,  0);
        check("rst_req_ready", req_ready, 0);
        check("rst_grant_id",  grant_id,  0);
        check("rst_busy",      busy,      0);
        tick();
        snk_reset_n = 1'b1;
        repeat (3) tick();

        // Scenario 1: req0 sends 5,1,9
        set_word(0, 1'b1, 1'b0, 8'd5);
        tick();
        check("s1_grant_id",    grant_id,  0);
        check("s1_grant_ready", req_ready, 4'b0001);
        check("s1_grant_novld", srt_valid, 0);
        check("s1_grant_busy",  busy,      1);
        tick();
        check("s1_w0_valid", srt_valid, 1);
        check("s1_w0_data",  srt_data,  5);
        check("s1_w0_sop",   srt_sop,   1);
        check("s1_w0_eop",   srt_eop,   0);
        set_word(0, 1'b0, 1'b0, 8'd1);
        tick();
        check("s1_w1_data",  srt_data,  1);
        check("s1_w1_sop",   srt_sop,   0);
        check("s1_w1_eop",   srt_eop,   0);
        set_word(0, 1'b0, 1'b1, 8'd9);
        tick();
        check("s1_w2_data",  srt_data,  9);
        check("s1_w2_sop",   srt_sop,   0);
        check("s1_w2_eop",   srt_eop,   1);
        clr_req(0);
        tick();
        check("s1_wb_valid", srt_valid, 0);
        check("s1_wb_ready", req_ready, 0);
        check("s1_wb_busy",  busy,      1);
        srt_ready = 1'b0;
        repeat (4) tick();
        check("s1_wd_busy",  busy,      1);
        srt_ready = 1'b1;
        repeat (4) tick();
        check("s1_idle_busy", busy,     0);

        // Scenario 2: req1 and req2 sop together with ptr=0
        pulse_reset();
        set_word(1, 1'b1, 1'b0, 8'h11);
        set_word(2, 1'b1, 1'b1, 8'h2F);
        tick();
        check("s2_gnt1_id",    grant_id,  1);
        check("s2_gnt1_ready", req_ready, 4'b0010);
        tick();
        check("s2_r1w0_data",  srt_data,  8'h11);
        check("s2_r1w0_sop",   srt_sop,   1);
        set_word(1, 1'b0, 1'b1, 8'h12);
        tick();
        check("s2_r1w1_data",  srt_data,  8'h12);
        check("s2_r1w1_eop",   srt_eop,   1);
        check("s2_r2_stalled", req_ready, 0);
        clr_req(1);
        clr_req(2);
        handshake();
        check("s2_idle_busy",  busy,      0);
        set_word(2, 1'b1, 1'b1, 8'h2F);
        tick();
        check("s2_gnt2_id",    grant_id,  2);
        check("s2_gnt2_ready", req_ready, 4'b0100);
        tick();
        check("s2_r2_valid",   srt_valid, 1);
        check("s2_r2_data",    srt_data,  8'h2F);
        clr_req(2);
        handshake();

        // Scenario 6: req0 and req3 together; ptr=3 so req3 wins; single word A5
        set_word(0, 1'b1, 1'b1, 8'h0F);
        set_word(3, 1'b1, 1'b1, 8'hA5);
        tick();
        check("s6_gnt3_id",    grant_id,  3);
        check("s6_gnt3_ready", req_ready, 4'b1000);
        tick();
        check("s6_valid", srt_valid, 1);
        check("s6_data",  srt_data,  8'hA5);
        check("s6_sop",   srt_sop,   1);
        check("s6_eop",   srt_eop,   1);
        clr_req(0);
        clr_req(3);
        tick();
        check("s6_after_valid", srt_valid, 0);
        handshake();

        // Scenario 3: req0 sends 6 words with MAX_LENGTH=4
        set_word(0, 1'b1, 1'b0, 8'h40);
        tick();
        check("s3_gnt0_id", grant_id, 0);
        for (int i = 0; i < 6; i++) begin
            set_word(0, (i == 0), (i == 5), 8'(8'h40 + i));
            check($sformatf("s3_ready_%0d", i), req_ready, 4'b0001);
            tick();
            check($sformatf("s3_valid_%0d", i), srt_valid, (i < ML));
            check($sformatf("s3_eop_%0d", i),   srt_eop,   (i == ML - 1));
            if (i < ML) begin
                check($sformatf("s3_data_%0d", i), srt_data, 8'h40 + i);
            end
        end
        clr_req(0);
        check("s3_wb_busy",  busy,      1);
        check("s3_wb_ready", req_ready, 0);
`ifdef SORTER_ARB_STATS_EN
        check("s3_trunc_cnt", trunc_cnt, 1);
        check("s3_pkt_cnt",   pkt_cnt,   3);
`endif
        handshake();

        // Scenario 4: srt_ready never drops -> timeout back to IDLE
        set_word(1, 1'b1, 1'b1, 8'h77);
        tick();
        check("s4_gnt_id", grant_id, 1);
        tick();
        check("s4_eop", srt_eop, 1);
        clr_req(1);
        n = 0;
        while (busy && n < 100) begin
            tick();
            n++;
        end
        check("s4_timeout_window", (n >= BTO - 2) && (n <= BTO + 2), 1);
        set_word(2, 1'b1, 1'b0, 8'h81);
        tick();
        check("s4_next_gnt_id", grant_id, 2);
        check("s4_next_busy",   busy,     1);

        // Scenario 5: async reset in the middle of word 2
        tick();
        check("s5_w0_data", srt_data, 8'h81);
        set_word(2, 1'b0, 1'b0, 8'h82);
        #2;
        snk_reset_n = 1'b0;
        #1;
        check("s5_rst_valid", srt_valid, 0);
        check("s5_rst_ready", req_ready, 0);
        check("s5_rst_busy",  busy,      0);
        check("s5_rst_gnt",   grant_id,  0);
        clr_req(2);
        tick();
        snk_reset_n = 1'b1;
        repeat (3) tick();
        set_word(2, 1'b1, 1'b1, 8'h90);
        tick();
        check("s5_regrant_id",    grant_id,  2);
        check("s5_regrant_ready", req_ready, 4'b0100);
        tick();
        check("s5_beat_data", srt_data, 8'h90);
        check("s5_beat_sop",  srt_sop,  1);
        check("s5_beat_eop",  srt_eop,  1);
        clr_req(2);
        tick();

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
